div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage. It consumes the decoded `divE`/`hassignE` controls and the E-stage operands, and stalls the pipeline while dividing. It delivers `{remainder, quotient}` to the HI/LO write path. Exceptions or flushes abort it.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; result is 2*WIDTH.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start_i`  in  1  DIV/DIVU present in E (divE); held high by pipeline while stalled
- `signed_i`  in  1  1 = DIV (signed), 0 = DIVU; sampled with start
- `annul_i`  in  1  flush/exception; aborts any operation
- `a_i`  in  WIDTH  dividend (rs)
- `b_i`  in  WIDTH  divisor (rt)
- `stall_o`  out  1  hold F/D/E, bubble M
- `ready_o`  out  1  result valid this cycle (one-cycle pulse)
- `result_o`  out  2*WIDTH  {remainder → HI, quotient → LO}

## Operation
- State machine: IDLE, BUSY, DONE.
- Internal state: 6-bit counter, 2*WIDTH+1 partial-remainder/quotient register, latched divisor magnitude, sign flags.
- IDLE:
  - On `start_i & ~annul_i`, latch |a|, |b| (magnitudes only if `signed_i`), plus neg_q = sa^sb and neg_r = sa.
  - If b_i == 0, go to DONE; otherwise go to BUSY with counter=0.
  - With no start, stay in IDLE.
- BUSY, one iteration per cycle:
  - Shift the remainder:quotient register left 1.
  - Trial subtract the divisor.
  - If non-negative, keep the difference and set quotient LSB=1; else restore.
  - After iteration WIDTH-1 (counter==31), go to DONE.
- DONE, entry update (`result_o` registered on entry):
  - Quotient is negated if neg_q; remainder is negated if neg_r.
  - Divide by zero: quotient = all ones, remainder = dividend unmodified (raw a_i), independent of sign.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (wraps, no trap).
- DONE exit: `ready_o`=1 for exactly one cycle, then IDLE unconditionally.
- Back-to-back DIVs: a new `start_i` seen in IDLE on the following cycle begins a new operation. There is no re-trigger of the finished one, because the pipeline advances on the DONE cycle.
- `annul_i`:
  - In any state, next state = IDLE and the counter is cleared; `result_o` is not updated.
  - Same-cycle start+annul in IDLE: ignored.
  - In DONE, `ready_o` still pulses but the consumer drops it.
- `result_o` holds its last value except on DONE entry.

## Timing
- Reset values: state=IDLE, `stall_o`=0, `ready_o`=0, `result_o`=0, counter=0.
- `stall_o` (combinational): (IDLE & `start_i` & ~`annul_i`) | BUSY.
  - It is 0 in DONE, so the instruction advances with the result that cycle.
- Normal latency: cycle 0 = start seen in IDLE, `stall_o`=1; cycles 1–32 BUSY, `stall_o`=1; cycle 33 DONE, `ready_o`=1, `stall_o`=0. That is 33 stall cycles.
- Divide-by-zero latency: cycle 0 IDLE stall; cycle 1 DONE. That is 1 stall cycle.
- `signed_i`, `a_i`, `b_i` are only sampled in IDLE at start; later changes are ignored.
- `rst` mid-operation: IDLE next cycle; `result_o` cleared to 0.
- `rst` has priority over `annul_i`, which has priority over `start_i`.

## Test plan
- DIVU 100/7: `stall_o` high cycles 0–32; cycle 33 `ready_o`=1, `result_o` = {0x00000002, 0x0000000E}.
- DIV −7/2 (0xFFFFFFF9, 0x2), `signed_i`=1: result {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7/−2: result {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000/0xFFFFFFFF signed: result {0x00000000, 0x80000000} at cycle 33. DIVU 0xFFFFFFFF/1: result {0, 0xFFFFFFFF}.
- DIVU 0x1234/0: one stall cycle; cycle 1 `ready_o`=1, result {0x00001234, 0xFFFFFFFF}.
- Abort cases:
  - `annul_i` at cycle 10: IDLE at cycle 11, `stall_o`=0, no `ready_o`, `result_o` unchanged.
  - `rst` at cycle 10: same, except `result_o`=0.
- Back-to-back: 100/7 then 9/3 with `start_i` held. First `ready_o` at cycle 33; second start in IDLE at cycle 34; second result {0, 3} at cycle 67.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in execute.
// Stalls the pipeline while iterating; result is {remainder, quotient}.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic                 annul_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 stall_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t               state;
    logic [5:0]           cnt;
    logic [2*WIDTH:0]     rq;
    logic [WIDTH-1:0]     divisor;
    logic                 negQ;
    logic                 negR;
    logic [2*WIDTH-1:0]   resultQ;

    logic                 signA;
    logic                 signB;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;

    logic [WIDTH+1:0]     hi;
    logic [WIDTH+1:0]     diff;
    logic [2*WIDTH:0]     rqNext;
    logic [WIDTH-1:0]     quoNext;
    logic [WIDTH-1:0]     remNext;
    logic [WIDTH-1:0]     quoOut;
    logic [WIDTH-1:0]     remOut;

    assign signA = signed_i & a_i[WIDTH-1];
    assign signB = signed_i & b_i[WIDTH-1];
    assign magA  = signA ? -a_i : a_i;
    assign magB  = signB ? -b_i : b_i;

    // Shifted partial remainder picks up the next dividend bit from rq.
    assign hi   = rq[2*WIDTH:WIDTH-1];
    assign diff = hi - {2'b00, divisor};

    assign rqNext = diff[WIDTH+1]
                  ? {hi[WIDTH:0], rq[WIDTH-2:0], 1'b0}
                  : {diff[WIDTH:0], rq[WIDTH-2:0], 1'b1};

    assign quoNext = rqNext[WIDTH-1:0];
    assign remNext = rqNext[2*WIDTH-1:WIDTH];
    assign quoOut  = negQ ? -quoNext : quoNext;
    assign remOut  = negR ? -remNext : remNext;

    assign stall_o  = ((state == IDLE) & start_i & ~annul_i)
                    | (state == BUSY);
    assign ready_o  = (state == DONE);
    assign result_o = resultQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rq      <= '0;
            divisor <= '0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            resultQ <= '0;
        end else if (annul_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        negQ    <= signA ^ signB;
                        negR    <= signA;
                        divisor <= magB;
                        rq      <= {{(WIDTH+1){1'b0}}, magA};
                        cnt     <= '0;
                        // Divide by zero skips iteration entirely.
                        if (b_i == '0) begin
                            resultQ <= {a_i, {WIDTH{1'b1}}};
                            state   <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rq  <= rqNext;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST) begin
                        resultQ <= {remOut, quoOut};
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, random
// operands against an arithmetic reference, abort and back-to-back flows.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startIn = 1'b0;
    logic        sgn = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] aIn = '0;
    logic [31:0] bIn = '0;
    logic        stall;
    logic        ready;
    logic [63:0] result;

    int total = 0;
    int fails = 0;
    int cyc = 0;
    logic [63:0] lastExp = '0;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (startIn),
        .signed_i (sgn),
        .annul_i  (annul),
        .a_i      (aIn),
        .b_i      (bIn),
        .stall_o  (stall),
        .ready_o  (ready),
        .result_o (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit integer division, truncated to 32-bit fields.
    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called at a negedge with the DUT idle; returns at the ready negedge.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        logic [63:0] exp;
        int lat;
        int stalls;
        int n;
        exp = model(a, b, s);
        lat = (b == 32'd0) ? 1 : 33;
        startIn = 1'b1;
        sgn = s;
        aIn = a;
        bIn = b;
        #1;
        chk("stallAtStart", 64'(stall), 64'd1);
        chk("noReadyAtStart", 64'(ready), 64'd0);
        stalls = 1;
        @(negedge clk);
        n = 1;
        aIn = $urandom;
        bIn = $urandom;
        sgn = 1'($urandom);
        while (!ready && n < 100) begin
            if (stall) stalls++;
            @(negedge clk);
            n++;
        end
        chk("readyPulse", 64'(ready), 64'd1);
        chk("latency", 64'(n), 64'(lat));
        chk("stallCycles", 64'(stalls), 64'(lat));
        chk("stallInDone", 64'(stall), 64'd0);
        chk("result", result, exp);
        lastExp = exp;
    endtask

    task automatic endOp();
        startIn = 1'b0;
        @(negedge clk);
        chk("readyOneCycle", 64'(ready), 64'd0);
        chk("stallIdle", 64'(stall), 64'd0);
    endtask

    task automatic noReadyFor(input int cycles);
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ready) saw = 1'b1;
        end
        chk("noReadyAfterAbort", 64'(saw), 64'd0);
    endtask

    initial begin
        int t0;
        logic [31:0] ra;
        logic [31:0] rb;
        logic rs;

        repeat (2) @(negedge clk);
        chk("rstStall", 64'(stall), 64'd0);
        chk("rstReady", 64'(ready), 64'd0);
        chk("rstResult", result, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        runOp(32'd100, 32'd7, 1'b0);
        chk("divu100_7", result, {32'h2, 32'hE});
        endOp();
        runOp(32'hFFFF_FFF9, 32'h2, 1'b1);
        chk("divNeg7_2", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        endOp();
        runOp(32'h7, 32'hFFFF_FFFE, 1'b1);
        chk("div7_neg2", result, {32'h1, 32'hFFFF_FFFD});
        endOp();
        runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("divOverflow", result, {32'h0, 32'h8000_0000});
        endOp();
        runOp(32'hFFFF_FFFF, 32'h1, 1'b0);
        chk("divuMax_1", result, {32'h0, 32'hFFFF_FFFF});
        endOp();
        runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        endOp();
        runOp(32'h1234, 32'h0, 1'b0);
        chk("divuByZero", result, {32'h1234, 32'hFFFF_FFFF});
        endOp();
        runOp(32'hFFFF_FFFB, 32'h0, 1'b1);
        endOp();

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (i % 4 == 1) rb = -rb;
            rs = 1'($urandom);
            runOp(ra, rb, rs);
            endOp();
        end

        // Back-to-back with start held high across DONE.
        t0 = cyc;
        runOp(32'd100, 32'd7, 1'b0);
        aIn = 32'd9;
        bIn = 32'd3;
        sgn = 1'b0;
        @(negedge clk);
        chk("b2bSecondStart", 64'(cyc - t0), 64'd34);
        runOp(32'd9, 32'd3, 1'b0);
        chk("b2bResult", result, {32'h0, 32'h3});
        chk("b2bCycle", 64'(cyc - t0), 64'd67);
        endOp();

        // Same-cycle start and annul in IDLE is ignored.
        startIn = 1'b1;
        annul = 1'b1;
        aIn = 32'd50;
        bIn = 32'd5;
        #1;
        chk("startAnnulStall", 64'(stall), 64'd0);
        @(negedge clk);
        startIn = 1'b0;
        annul = 1'b0;
        noReadyFor(40);
        chk("startAnnulResult", result, lastExp);

        // Annul mid-operation.
        startIn = 1'b1;
        sgn = 1'b0;
        aIn = 32'd100;
        bIn = 32'd7;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        startIn = 1'b0;
        #1;
        chk("annulStall", 64'(stall), 64'd0);
        chk("annulReady", 64'(ready), 64'd0);
        chk("annulResultHeld", result, lastExp);
        noReadyFor(40);
        chk("annulResultLater", result, lastExp);

        // Reset mid-operation.
        startIn = 1'b1;
        aIn = 32'd100;
        bIn = 32'd7;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        startIn = 1'b0;
        #1;
        chk("midRstStall", 64'(stall), 64'd0);
        chk("midRstReady", 64'(ready), 64'd0);
        chk("midRstResult", result, 64'd0);
        noReadyFor(40);

        // Divider still works after the reset.
        @(negedge clk);
        runOp(32'd1000, 32'd33, 1'b0);
        endOp();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
